// File: rtl/day4_stream_feeder.sv
// day4_stream_feeder
//   Streams the puzzle text from an on-chip byte ROM into the Day 4 solver.
//   It sends len bytes from address 0 upward with valid/ready handshaking,
//   then one idle gap cycle, then a trailing newline (0x0A). After that it
//   waits a fixed drain period, captures the solver's count and raises done.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      one-cycle pulse; starts a run when idle
//   len        number of ROM bytes to stream; sampled on an accepted start
//   mem_rd_en  ROM read strobe
//   mem_addr   ROM read address
//   mem_data   ROM read data, valid one cycle after mem_rd_en
//   char_out   stream byte to the solver
//   valid_out  stream valid to the solver
//   ready_in   downstream ready
//   result_in  solver's total_accessible count
//   result     captured count; holds until the next capture or reset
//   busy       high from the accepted start until done
//   done       level; set on capture, cleared by the next accepted start
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// FETCH | issuing ROM reads and streaming bytes out of the FIFO
// GAP   | one cycle with valid_out low
// NL    | presenting the trailing 0x0A until it is accepted
// DRAIN | counting DRAIN_CYCLES cycles, then capture result_in

module day4_stream_feeder #(
    parameter int ADDR_W       = 16,
    parameter int DRAIN_CYCLES = 2100,
    parameter int RESULT_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   len,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_data,
    output logic [7:0]          char_out,
    output logic                valid_out,
    input  logic                ready_in,
    input  logic [RESULT_W-1:0] result_in,
    output logic [RESULT_W-1:0] result,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GAP,
        S_NL,
        S_DRAIN
    } state_t;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                inflight;
    logic [7:0]          fifo_mem [0:1];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic                fifo_pop;
    logic [1:0]          occ_after_pop;
    logic                reads_left;
    logic                issue;
    logic                fetch_done;
    logic                start_ok;
    logic                nl_accept;
    logic                drain_tc;

    assign mem_addr = rd_addr;

    // Occupancy is counted after this cycle's pop so that a byte leaving the
    // FIFO frees its slot for a read in the same cycle; that keeps the
    // stream back-to-back while FIFO + in-flight never exceeds two entries.
    assign fifo_pop      = (fifo_cnt != 2'd0) && ready_in;
    assign occ_after_pop = fifo_cnt - {1'b0, fifo_pop};
    assign reads_left    = (rd_addr != len_q);
    assign issue         = (state == S_FETCH) && reads_left &&
                           ((occ_after_pop + {1'b0, inflight}) < 2'd2);

    // Leave FETCH on the cycle the last byte goes out, so exactly one idle
    // cycle (GAP) separates it from the newline.
    assign fetch_done = !reads_left && !inflight &&
                        ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && fifo_pop));

    always_comb begin
        state_next = state;
        mem_rd_en  = issue;
        valid_out  = 1'b0;
        char_out   = 8'h00;
        start_ok   = 1'b0;
        nl_accept  = 1'b0;
        drain_tc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fifo_cnt != 2'd0) begin
                    valid_out = 1'b1;
                    char_out  = fifo_mem[rd_ptr];
                end
                if (fetch_done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                state_next = S_NL;
            end
            S_NL: begin
                valid_out = 1'b1;
                char_out  = 8'h0A;
                if (ready_in) begin
                    nl_accept  = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    drain_tc   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            len_q       <= '0;
            rd_addr     <= '0;
            inflight    <= 1'b0;
            fifo_mem[0] <= 8'h00;
            fifo_mem[1] <= 8'h00;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            drain_cnt   <= '0;
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;

            if (start_ok) begin
                len_q   <= len;
                rd_addr <= '0;
                done    <= 1'b0;
                busy    <= 1'b1;
            end else if (issue) begin
                rd_addr <= rd_addr + 1'b1;
            end

            if (inflight) begin
                fifo_mem[wr_ptr] <= mem_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, fifo_pop};

            if (nl_accept) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == S_DRAIN) && !drain_tc) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (drain_tc) begin
                result <= result_in;
                done   <= 1'b1;
                busy   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/day4_stream_feeder.md
Name: day4_stream_feeder

Overview:
- Drives the solver's character-stream input from an on-chip byte ROM holding the puzzle text; replaces the bench-side driver so the full Day 4 flow runs in hardware.
- Reads `len` bytes from address 0 upward and streams them with valid/ready, one byte per cycle when not stalled.
- After the last byte it sends one idle gap cycle, then a trailing 0x0A, then waits a fixed drain period.
- It then captures the solver's `total_accessible` and signals done.

Parameters:
- ADDR_W, 16, ROM address width; max stream length 2^ADDR_W-1.
- DRAIN_CYCLES, 2100, cycles to wait after the trailing newline is accepted, before capturing the result.
- RESULT_W, 32, width of the solver count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- len  in  ADDR_W  number of ROM bytes to stream; sampled on an accepted start.
- mem_rd_en  out  1  ROM read strobe.
- mem_addr  out  ADDR_W  ROM read address.
- mem_data  in  8  ROM read data; valid exactly 1 cycle after mem_rd_en.
- char_out  out  8  stream byte to the solver's char_in.
- valid_out  out  1  stream valid to the solver's valid_in.
- ready_in  in  1  downstream ready; tie high for the current solver.
- result_in  in  RESULT_W  solver's total_accessible.
- result  out  RESULT_W  captured count.
- busy  out  1  high from the accepted start until done.
- done  out  1  level; high after capture, cleared by the next accepted start or by reset.

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, char_out=0, valid_out=0, busy=0, done=0, result=0.
- Reset also clears the FIFO, the in-flight read flag, and all counters; any read in flight during reset is discarded.
- A byte transfers on any cycle with valid_out && ready_in.
- While valid_out=1 and ready_in=0, char_out must hold stable.
- Output buffer is a 2-entry FIFO.
  - A read is issued only if (FIFO occupancy + reads in flight) < 2, so no ROM data is ever dropped under backpressure.
  - mem_data is written into the FIFO at the end of the cycle it is valid.
  - valid_out follows FIFO non-empty.
- States:
  - IDLE: start=1 → latch len, clear done, set busy → FETCH; start is ignored in every other state.
  - FETCH: issue reads at addresses 0..len-1 under the FIFO rule. When the last read has been issued and the FIFO has drained → GAP. len=0 → GAP immediately, with no ROM reads.
  - GAP: exactly one cycle with valid_out=0, char_out=0 → NL.
  - NL: char_out=0x0A, valid_out=1, held until ready_in=1 → DRAIN. The count starts on the cycle after the newline is accepted.
  - DRAIN: counts DRAIN_CYCLES cycles. At terminal count, result<=result_in, done<=1, busy<=0 → IDLE.
- Timing with ready_in held high:
  - start sampled at edge E → mem_rd_en=1 with addr 0 in cycle E+1.
  - valid_out first high with byte 0 in cycle E+3.
  - Bytes follow back-to-back at 1 per cycle.
- Address counter is ADDR_W bits and never wraps: the highest address read is len-1.
- result holds its value until the next capture or reset; it is not cleared by start.
- If start and reset are asserted together, reset wins.

Test Plan:
- ROM = 0x40,0x2E,0x40,0x0A, len=4, ready_in=1, start → bytes 40,2E,40,0A on valid_out in cycles E+3..E+6. Then 1 cycle valid_out=0, then 0A. done rises DRAIN_CYCLES+1 cycles after the newline is accepted; busy=0 with it.
- Same stream with ready_in low for 3 cycles when byte 2 is presented → char_out holds 0x40 during the stall, no byte is lost or duplicated, and mem_rd_en never has more than 2 outstanding entries.
- len=0, start → no mem_rd_en pulses. The gap cycle, then a single 0x0A, then drain; result captures result_in.
- Second start pulse mid-stream → ignored; the byte sequence is unchanged. After done, a new start clears done the following cycle and replays the stream.
- reset asserted during FETCH at byte 5 → next cycle all outputs at reset values, valid_out=0. A fresh start restarts from address 0.
- Integration: full puzzle ROM, len=18905, DRAIN_CYCLES=2100, driving the solver → result=1424 and done=1.
